// File: rtl/aes_encrypt_sequencer.sv
// -----------------------------------------------------------------------------
// aes_encrypt_sequencer
//
// Sits between a 32-bit valid/ready word stream and a 128-bit Encrypt core.
// It collects four plaintext words into one block and pulses enc_enable for a
// single cycle. After a fixed ENC_LATENCY it captures the ciphertext and
// streams it back out as four 32-bit words. Only one block is in flight at a
// time. The key sits in a local register that is loaded with key_load.
//
// Bit order: the [0:127] numbering used by the Encrypt core maps onto [127:0]
// here, so bit 0 (the MSB) is bit 127. Word n occupies bits [127-32n -: 32],
// which means word 0 is the most significant word.
//
// Ports
//   clk            : single clock, all state on posedge
//   reset          : asynchronous, active-low, clears all state
//   key_load/key   : load key_reg (honoured only while collecting)
//   in_valid/in_ready/in_data    : plaintext word stream, word 0 first
//   out_valid/out_ready/out_data : ciphertext word stream, word 0 first
//   enc_enable     : one-cycle launch pulse to Encrypt (registered)
//   enc_plaintext  : assembled plaintext block (pt_reg)
//   enc_key        : current key (key_reg)
//   enc_ciphertext : result from Encrypt, sampled ENC_LATENCY edges later
//   busy           : high whenever not collecting
//   blocks_done    : completed-block counter, wraps
// -----------------------------------------------------------------------------
module aes_encrypt_sequencer #(
  parameter int unsigned ENC_LATENCY = 12  // legal range 1..255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_load,
  input  logic [127:0] key,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         enc_enable,
  output logic [127:0] enc_plaintext,
  output logic [127:0] enc_key,
  input  logic [127:0] enc_ciphertext,
  output logic         busy,
  output logic [15:0]  blocks_done
);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  localparam logic [7:0] LAT_LOAD = 8'(ENC_LATENCY - 1);

  state_e       state_q, state_d;
  logic         key_loaded_q, key_loaded_d;
  logic [1:0]   word_idx_q, word_idx_d;
  logic [127:0] pt_q, pt_d;
  logic [127:0] ct_q, ct_d;
  logic [127:0] key_q, key_d;
  logic [7:0]   lat_cnt_q, lat_cnt_d;
  logic [15:0]  blocks_q, blocks_d;
  logic         enc_enable_q;

  // Handshakes are judged on registered readiness only, so neither ready
  // signal has a combinational path from the opposite side's valid.
  logic in_fire, out_fire;
  assign in_fire  = in_valid  & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch instead of combinational logic.
    state_d      = state_q;
    key_loaded_d = key_loaded_q;
    word_idx_d   = word_idx_q;
    pt_d         = pt_q;
    ct_d         = ct_q;
    key_d        = key_q;
    lat_cnt_d    = lat_cnt_q;
    blocks_d     = blocks_q;

    unique case (state_q)
      ST_COLLECT: begin
        // The key is taken before the word write, so a key_load on the same
        // edge as the 4th word applies to that block.
        if (key_load) begin
          key_d        = key;
          key_loaded_d = 1'b1;
        end
        if (in_fire) begin
          // Word n sits at the MSB end minus 32n; ~idx equals 3-idx.
          pt_d[{~word_idx_q, 5'd0} +: 32] = in_data;
          if (word_idx_q == 2'd3) begin
            word_idx_d = 2'd0;
            state_d    = ST_LAUNCH;
          end else begin
            word_idx_d = word_idx_q + 2'd1;
          end
        end
      end

      ST_LAUNCH: begin
        lat_cnt_d = LAT_LOAD;
        state_d   = ST_WAIT;
      end

      ST_WAIT: begin
        if (lat_cnt_q == 8'd0) begin
          ct_d    = enc_ciphertext;
          state_d = ST_DRAIN;
        end else begin
          lat_cnt_d = lat_cnt_q - 8'd1;
        end
      end

      ST_DRAIN: begin
        if (out_fire) begin
          if (word_idx_q == 2'd3) begin
            word_idx_d = 2'd0;
            blocks_d   = blocks_q + 16'd1;
            state_d    = ST_COLLECT;
          end else begin
            word_idx_d = word_idx_q + 2'd1;
          end
        end
      end

      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the data registers are reset as well as the control state, so a
      // reset leaves no stale plaintext, key or ciphertext on the outputs.
      state_q      <= ST_COLLECT;
      key_loaded_q <= 1'b0;
      word_idx_q   <= 2'd0;
      pt_q         <= '0;
      ct_q         <= '0;
      key_q        <= '0;
      lat_cnt_q    <= 8'd0;
      blocks_q     <= 16'd0;
      enc_enable_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register updates from the
      // values present before the edge regardless of statement order.
      state_q      <= state_d;
      key_loaded_q <= key_loaded_d;
      word_idx_q   <= word_idx_d;
      pt_q         <= pt_d;
      ct_q         <= ct_d;
      key_q        <= key_d;
      lat_cnt_q    <= lat_cnt_d;
      blocks_q     <= blocks_d;
      // The registered launch pulse is high exactly while state_q is LAUNCH.
      enc_enable_q <= (state_d == ST_LAUNCH);
    end
  end

  assign in_ready      = (state_q == ST_COLLECT) & key_loaded_q;
  assign out_valid     = (state_q == ST_DRAIN);
  assign out_data      = out_valid ? ct_q[{~word_idx_q, 5'd0} +: 32] : 32'd0;
  assign busy          = (state_q != ST_COLLECT);
  assign enc_enable    = enc_enable_q;
  assign enc_plaintext = pt_q;
  assign enc_key       = key_q;
  assign blocks_done   = blocks_q;

endmodule
